// File: rtl/mp_add_seq_if.sv
// Request/response handshake and external 16-bit adder slice bus for mp_add_seq.
interface mp_add_seq_if #(
    parameter int WORDS = 4
);
    localparam int W = 16 * WORDS;

    logic         in_valid;
    logic         in_ready;
    logic         in_op;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         in_cin;
    logic [15:0]  add_a;
    logic [15:0]  add_b;
    logic         add_cin;
    logic [15:0]  add_sum;
    logic         add_cout;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_sum;
    logic         out_cout;
    logic         out_ovf;
    logic         out_zero;

    modport slave (
        input  in_valid, in_op, in_a, in_b, in_cin, add_sum, add_cout, out_ready,
        output in_ready, add_a, add_b, add_cin, out_valid, out_sum, out_cout, out_ovf, out_zero
    );

    modport master (
        output in_valid, in_op, in_a, in_b, in_cin, add_sum, add_cout, out_ready,
        input  in_ready, add_a, add_b, add_cin, out_valid, out_sum, out_cout, out_ovf, out_zero
    );
endinterface

// File: rtl/mp_add_seq.sv
// Multi-precision add/subtract, one 16-bit slice per cycle through an external adder.
module mp_add_seq #(
    parameter int WORDS = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    mp_add_seq_if.slave bus
);
    localparam int W  = 16 * WORDS;
    localparam int CW = $clog2(WORDS);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state;
    logic [W-1:0]  a_q;
    logic [W-1:0]  b_q;
    logic [W-17:0] res_q;
    logic [W-1:0]  sum_q;
    logic [CW-1:0] cnt_q;
    logic          carry_q;
    logic          a_msb_q;
    logic          b_msb_q;
    logic          in_ready_q;
    logic          out_valid_q;
    logic          cout_q;
    logic          ovf_q;
    logic          zero_q;
    logic          run;
    logic [W-1:0]  res_next;

    assign run = (state == RUN);

    // Operands shift down one slice per cycle, so the active slice is always bits [15:0].
    assign bus.add_a   = run ? a_q[15:0] : '0;
    assign bus.add_b   = run ? b_q[15:0] : '0;
    assign bus.add_cin = run ? carry_q   : 1'b0;

    // Result fills from the top; after the last slice the full word is aligned.
    assign res_next = {bus.add_sum, res_q};

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_sum   = sum_q;
    assign bus.out_cout  = cout_q;
    assign bus.out_ovf   = ovf_q;
    assign bus.out_zero  = zero_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            res_q       <= '0;
            sum_q       <= '0;
            cnt_q       <= '0;
            carry_q     <= 1'b0;
            a_msb_q     <= 1'b0;
            b_msb_q     <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            zero_q      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_q        <= bus.in_a;
                        b_q        <= bus.in_op ? ~bus.in_b : bus.in_b;
                        carry_q    <= bus.in_op | bus.in_cin;
                        a_msb_q    <= bus.in_a[W-1];
                        b_msb_q    <= bus.in_op ? ~bus.in_b[W-1] : bus.in_b[W-1];
                        res_q      <= '0;
                        cnt_q      <= '0;
                        in_ready_q <= 1'b0;
                        state      <= RUN;
                    end
                end
                RUN: begin
                    a_q     <= {16'h0000, a_q[W-1:16]};
                    b_q     <= {16'h0000, b_q[W-1:16]};
                    res_q   <= res_next[W-1:16];
                    carry_q <= bus.add_cout;
                    cnt_q   <= cnt_q + 1'b1;
                    if (cnt_q == CW'(WORDS - 1)) begin
                        sum_q       <= res_next;
                        cout_q      <= bus.add_cout;
                        ovf_q       <= (a_msb_q == b_msb_q) && (bus.add_sum[15] != a_msb_q);
                        zero_q      <= ~|res_next;
                        out_valid_q <= 1'b1;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mp_add_seq.sv
// Directed and randomised checks of mp_add_seq at WORDS = 4, 2 and 8.
module tb_mp_add_seq;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    mp_add_seq_if #(.WORDS(4)) if4 ();
    mp_add_seq_if #(.WORDS(2)) if2 ();
    mp_add_seq_if #(.WORDS(8)) if8 ();

    mp_add_seq #(.WORDS(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(if4));
    mp_add_seq #(.WORDS(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(if2));
    mp_add_seq #(.WORDS(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(if8));

    // Behavioural stand-ins for the external 16-bit CLA adder.
    assign {if4.add_cout, if4.add_sum} = 17'(if4.add_a) + 17'(if4.add_b) + 17'(if4.add_cin);
    assign {if2.add_cout, if2.add_sum} = 17'(if2.add_a) + 17'(if2.add_b) + 17'(if2.add_cin);
    assign {if8.add_cout, if8.add_sum} = 17'(if8.add_a) + 17'(if8.add_b) + 17'(if8.add_cin);

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start4(input logic op, input logic [63:0] a, input logic [63:0] b, input logic cin);
        int n = 0;
        while (!if4.in_ready && n < 20) begin step(); n++; end
        if4.in_op = op; if4.in_a = a; if4.in_b = b; if4.in_cin = cin; if4.in_valid = 1'b1;
        step();
        if4.in_valid = 1'b0;
    endtask

    task automatic wait_done4(output int cyc);
        cyc = 0;
        while (!if4.out_valid && cyc < 40) begin step(); cyc++; end
    endtask

    task automatic release4();
        if4.out_ready = 1'b1;
        step();
        if4.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #2;
        checks++; if (if4.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", if4.out_valid); end
        checks++; if (if4.out_sum !== 64'h0) begin errors++; $display("FAIL reset_out_sum: got %h want 0", if4.out_sum); end
        checks++; if ({if4.out_cout, if4.out_ovf, if4.out_zero} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b want 000", {if4.out_cout, if4.out_ovf, if4.out_zero}); end
        checks++; if ({if4.add_a, if4.add_b, if4.add_cin} !== 33'h0) begin errors++; $display("FAIL reset_adder_bus: got %h want 0", {if4.add_a, if4.add_b, if4.add_cin}); end
        step(); step();
        @(negedge clk) rst_n = 1'b1;
        #1;
        checks++; if (if4.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", if4.in_ready); end
        checks++; if (if4.out_valid !== 1'b0) begin errors++; $display("FAIL reset_release_valid: got %b want 0", if4.out_valid); end
    endtask

    task automatic test_add_carry();
        int cyc;
        start4(1'b0, 64'h0000_0000_0000_FFFF, 64'h0000_0000_0000_0001, 1'b0);
        checks++; if ({if4.add_a, if4.add_b, if4.add_cin} !== {16'hFFFF, 16'h0001, 1'b0}) begin errors++; $display("FAIL carry_slice0: got %h %h %b want ffff 0001 0", if4.add_a, if4.add_b, if4.add_cin); end
        step();
        checks++; if ({if4.add_a, if4.add_cin} !== {16'h0000, 1'b1}) begin errors++; $display("FAIL carry_slice1: got add_a %h add_cin %b want 0000 1", if4.add_a, if4.add_cin); end
        wait_done4(cyc);
        checks++; if (cyc + 1 !== 4) begin errors++; $display("FAIL carry_latency: got %0d want 4", cyc + 1); end
        checks++; if (if4.out_sum !== 64'h0000_0000_0001_0000) begin errors++; $display("FAIL carry_sum: got %h want 0000000000010000", if4.out_sum); end
        checks++; if ({if4.out_cout, if4.out_ovf, if4.out_zero} !== 3'b000) begin errors++; $display("FAIL carry_flags: got %b want 000", {if4.out_cout, if4.out_ovf, if4.out_zero}); end
        release4();
    endtask

    task automatic test_wrap();
        int cyc;
        start4(1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1);
        wait_done4(cyc);
        checks++; if (cyc !== 4) begin errors++; $display("FAIL wrap_latency: got %0d want 4", cyc); end
        checks++; if (if4.out_sum !== 64'h0) begin errors++; $display("FAIL wrap_sum: got %h want 0", if4.out_sum); end
        checks++; if ({if4.out_cout, if4.out_ovf, if4.out_zero} !== 3'b101) begin errors++; $display("FAIL wrap_flags: got %b want 101", {if4.out_cout, if4.out_ovf, if4.out_zero}); end
        release4();
    endtask

    task automatic test_sub();
        int cyc;
        start4(1'b1, 64'h8000_0000_0000_0000, 64'h1, 1'b0);
        wait_done4(cyc);
        checks++; if (if4.out_sum !== 64'h7FFF_FFFF_FFFF_FFFF) begin errors++; $display("FAIL sub_min_sum: got %h want 7fffffffffffffff", if4.out_sum); end
        checks++; if ({if4.out_cout, if4.out_ovf, if4.out_zero} !== 3'b110) begin errors++; $display("FAIL sub_min_flags: got %b want 110", {if4.out_cout, if4.out_ovf, if4.out_zero}); end
        release4();
        start4(1'b1, 64'h5, 64'h7, 1'b1);
        wait_done4(cyc);
        checks++; if (cyc !== 4) begin errors++; $display("FAIL sub_latency: got %0d want 4", cyc); end
        checks++; if (if4.out_sum !== 64'hFFFF_FFFF_FFFF_FFFE) begin errors++; $display("FAIL sub_neg_sum: got %h want fffffffffffffffe", if4.out_sum); end
        checks++; if ({if4.out_cout, if4.out_ovf, if4.out_zero} !== 3'b000) begin errors++; $display("FAIL sub_neg_flags: got %b want 000", {if4.out_cout, if4.out_ovf, if4.out_zero}); end
        release4();
    endtask

    task automatic test_hold();
        int cyc;
        logic ok;
        start4(1'b0, 64'h1234, 64'h1111, 1'b0);
        wait_done4(cyc);
        checks++; if (cyc !== 4) begin errors++; $display("FAIL hold_latency: got %0d want 4", cyc); end
        for (int i = 0; i < 10; i++) begin
            if4.in_valid = i[0];
            if4.in_op = ~i[0];
            if4.in_a = {$urandom, $urandom};
            if4.in_b = {$urandom, $urandom};
            step();
            ok = (if4.out_valid === 1'b1) && (if4.in_ready === 1'b0) && (if4.out_sum === 64'h2345) &&
                 ({if4.out_cout, if4.out_ovf, if4.out_zero} === 3'b000) && ({if4.add_a, if4.add_b, if4.add_cin} === 33'h0);
            checks++; if (!ok) begin errors++; $display("FAIL hold_stable[%0d]: got v=%b r=%b sum=%h want v=1 r=0 sum=2345", i, if4.out_valid, if4.in_ready, if4.out_sum); end
        end
        if4.in_valid = 1'b1; if4.in_op = 1'b0; if4.in_a = 64'h1; if4.in_b = 64'h1;
        release4();
        if4.in_valid = 1'b0;
        checks++; if ({if4.out_valid, if4.in_ready} !== 2'b01) begin errors++; $display("FAIL hold_release: got valid/ready %b want 01", {if4.out_valid, if4.in_ready}); end
        step();
        checks++; if ({if4.in_ready, if4.out_sum} !== {1'b1, 64'h2345}) begin errors++; $display("FAIL idle_hold: got ready %b sum %h want 1 2345", if4.in_ready, if4.out_sum); end
    endtask

    task automatic test_reset_mid_run();
        int cyc;
        start4(1'b0, 64'hFFFF_FFFF, 64'h1, 1'b0);
        step(); step();
        rst_n = 1'b0;
        #1;
        checks++; if ({if4.out_valid, if4.out_sum, if4.out_cout, if4.out_ovf, if4.out_zero} !== 68'h0) begin errors++; $display("FAIL midrun_outputs: got valid %b sum %h want 0 0", if4.out_valid, if4.out_sum); end
        checks++; if ({if4.add_a, if4.add_b, if4.add_cin} !== 33'h0) begin errors++; $display("FAIL midrun_adder_bus: got %h want 0", {if4.add_a, if4.add_b, if4.add_cin}); end
        step();
        @(negedge clk) rst_n = 1'b1;
        step(); step(); step(); step(); step();
        checks++; if ({if4.out_valid, if4.in_ready, if4.out_sum} !== {2'b01, 64'h0}) begin errors++; $display("FAIL midrun_no_partial: got valid %b ready %b sum %h want 0 1 0", if4.out_valid, if4.in_ready, if4.out_sum); end
        start4(1'b0, 64'h3, 64'h4, 1'b0);
        wait_done4(cyc);
        checks++; if (cyc !== 4) begin errors++; $display("FAIL midrun_latency: got %0d want 4", cyc); end
        checks++; if (if4.out_sum !== 64'h7) begin errors++; $display("FAIL midrun_sum: got %h want 7", if4.out_sum); end
        release4();
    endtask

    task automatic test_back_to_back_w2();
        for (int n = 0; n < 24; n++) begin
            logic [31:0] a, b;
            logic [32:0] r;
            logic op, cin, ovf;
            int cyc, w;
            a = $urandom; b = $urandom;
            if (n % 6 == 0) a = '1;
            if (n % 6 == 1) b = 32'h8000_0000;
            if (n % 6 == 2) b = a;
            op = 1'($urandom_range(0, 1)); cin = 1'($urandom_range(0, 1));
            if (!op) begin
                r = {1'b0, a} + {1'b0, b} + 33'(cin);
                ovf = (a[31] == b[31]) && (r[31] != a[31]);
            end else begin
                r = {(a >= b), a - b};
                ovf = (a[31] != b[31]) && (r[31] != a[31]);
            end
            w = 0;
            while (!if2.in_ready && w < 20) begin step(); w++; end
            if2.in_op = op; if2.in_a = a; if2.in_b = b; if2.in_cin = cin; if2.in_valid = 1'b1;
            step();
            if2.in_valid = 1'b0;
            cyc = 0;
            while (!if2.out_valid && cyc < 40) begin step(); cyc++; end
            checks++; if (cyc !== 2) begin errors++; $display("FAIL w2_latency[%0d]: got %0d want 2", n, cyc); end
            repeat ($urandom_range(0, 3)) step();
            checks++; if (if2.out_sum !== r[31:0]) begin errors++; $display("FAIL w2_sum[%0d]: got %h want %h", n, if2.out_sum, r[31:0]); end
            checks++; if ({if2.out_valid, if2.out_cout, if2.out_ovf, if2.out_zero} !== {1'b1, r[32], ovf, r[31:0] == 32'h0}) begin errors++; $display("FAIL w2_flags[%0d]: got %b want %b", n, {if2.out_valid, if2.out_cout, if2.out_ovf, if2.out_zero}, {1'b1, r[32], ovf, r[31:0] == 32'h0}); end
            if2.out_ready = 1'b1;
            step();
            if2.out_ready = 1'b0;
        end
    endtask

    task automatic test_back_to_back_w8();
        for (int n = 0; n < 16; n++) begin
            logic [127:0] a, b;
            logic [128:0] r;
            logic op, cin, ovf;
            int cyc, w;
            a = {$urandom, $urandom, $urandom, $urandom};
            b = {$urandom, $urandom, $urandom, $urandom};
            if (n % 5 == 0) a = '1;
            if (n % 5 == 1) b = a;
            if (n % 5 == 2) a = {1'b1, 127'h0};
            op = 1'($urandom_range(0, 1)); cin = 1'($urandom_range(0, 1));
            if (!op) begin
                r = {1'b0, a} + {1'b0, b} + 129'(cin);
                ovf = (a[127] == b[127]) && (r[127] != a[127]);
            end else begin
                r = {(a >= b), a - b};
                ovf = (a[127] != b[127]) && (r[127] != a[127]);
            end
            w = 0;
            while (!if8.in_ready && w < 20) begin step(); w++; end
            if8.in_op = op; if8.in_a = a; if8.in_b = b; if8.in_cin = cin; if8.in_valid = 1'b1;
            step();
            if8.in_valid = 1'b0;
            cyc = 0;
            while (!if8.out_valid && cyc < 40) begin step(); cyc++; end
            checks++; if (cyc !== 8) begin errors++; $display("FAIL w8_latency[%0d]: got %0d want 8", n, cyc); end
            repeat ($urandom_range(0, 3)) step();
            checks++; if (if8.out_sum !== r[127:0]) begin errors++; $display("FAIL w8_sum[%0d]: got %h want %h", n, if8.out_sum, r[127:0]); end
            checks++; if ({if8.out_valid, if8.out_cout, if8.out_ovf, if8.out_zero} !== {1'b1, r[128], ovf, r[127:0] == 128'h0}) begin errors++; $display("FAIL w8_flags[%0d]: got %b want %b", n, {if8.out_valid, if8.out_cout, if8.out_ovf, if8.out_zero}, {1'b1, r[128], ovf, r[127:0] == 128'h0}); end
            if8.out_ready = 1'b1;
            step();
            if8.out_ready = 1'b0;
        end
    endtask

    initial begin
        if4.in_valid = 1'b0; if4.in_op = 1'b0; if4.in_a = '0; if4.in_b = '0; if4.in_cin = 1'b0; if4.out_ready = 1'b0;
        if2.in_valid = 1'b0; if2.in_op = 1'b0; if2.in_a = '0; if2.in_b = '0; if2.in_cin = 1'b0; if2.out_ready = 1'b0;
        if8.in_valid = 1'b0; if8.in_op = 1'b0; if8.in_a = '0; if8.in_b = '0; if8.in_cin = 1'b0; if8.out_ready = 1'b0;
        test_reset();
        test_add_carry();
        test_wrap();
        test_sub();
        test_hold();
        test_reset_mid_run();
        test_back_to_back_w2();
        test_back_to_back_w8();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
